// File: rtl/dpu_requant_pkg.sv
// dpu_requant_pkg
// Shared widths, constants and per-stage payload types for the INT8
// requantization datapath (requant_int8) and its helpers.
//   ACC_W / SCALE_W / SHIFT_W : accumulator, scale and shift widths
//   LEAKY_MUL / LEAKY_SHIFT   : LeakyReLU slope 13/128
//   INT8_MIN / INT8_MAX       : output clamp limits
package dpu_requant_pkg;

  localparam int ACC_W   = 32;
  localparam int SCALE_W = 16;
  localparam int SHIFT_W = 5;

  // Internal widths: the bias add is exact at ACC_W+1 bits, and the product
  // with a zero-extended unsigned scale is exact at SUM_W+SCALE_W+1 bits.
  localparam int SUM_W  = ACC_W + 1;
  localparam int PROD_W = SUM_W + SCALE_W + 1;
  // One guard bit for the rounding increment, four more for the x13 leaky
  // multiply.
  localparam int RND_W  = PROD_W + 1;
  localparam int LKY_W  = RND_W + 4;

  localparam int LEAKY_MUL   = 13;
  localparam int LEAKY_SHIFT = 7;

  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;

  // Payload held after the bias add; scale still to be applied.
  typedef struct packed {
    logic signed [SUM_W-1:0]   value;
    logic        [SCALE_W-1:0] scale;
    logic        [SHIFT_W-1:0] shift;
    logic                      leaky_en;
  } s1_payload_t;

  // Payload held after the scale multiply.
  typedef struct packed {
    logic signed [PROD_W-1:0]  value;
    logic        [SHIFT_W-1:0] shift;
    logic                      leaky_en;
  } s2_payload_t;

endpackage

// File: rtl/sat_clamp_int8.sv
// sat_clamp_int8
// Combinational saturation of a wide signed value to INT8.
//   din  : signed input, IN_W bits (IN_W >= 8)
//   dout : din clamped to [INT8_MIN, INT8_MAX]
//   sat  : 1 when the clamp changed the value
module sat_clamp_int8
  import dpu_requant_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic signed [IN_W-1:0] din,
  output logic signed [7:0]      dout,
  output logic                   sat
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'(INT8_MAX);
  localparam logic signed [IN_W-1:0] MIN_V = IN_W'(INT8_MIN);

  always_comb begin
    dout = din[7:0];
    sat  = 1'b0;
    if (din > MAX_V) begin
      dout = 8'h7F;
      sat  = 1'b1;
    end else if (din < MIN_V) begin
      dout = 8'h80;
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/requant_int8.sv
// requant_int8
// Three-stage valid/ready requantization: INT32 accumulator -> INT8.
// Per element: (acc + bias) * scale, rounding arithmetic right shift,
// optional LeakyReLU (13/128), saturation to INT8.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : upstream handshake
//   acc_in, bias        : signed accumulator and bias
//   scale, shift        : unsigned multiplier and right-shift amount
//   leaky_en            : apply LeakyReLU to this element
//   out_valid/out_ready : downstream handshake
//   out_data, sat       : INT8 result and clamp flag (registered)
module requant_int8
  import dpu_requant_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [ACC_W-1:0]   acc_in,
  input  logic signed [ACC_W-1:0]   bias,
  input  logic        [SCALE_W-1:0] scale,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      leaky_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [7:0]         out_data,
  output logic                      sat
);

  // Round half up toward +inf, then arithmetic shift right.
  function automatic logic signed [RND_W-1:0] round_shift(
    input logic signed [PROD_W-1:0]  prod,
    input logic        [SHIFT_W-1:0] sh
  );
    logic signed [RND_W-1:0] ext;
    logic signed [RND_W-1:0] half;
    logic signed [RND_W-1:0] res;
    ext = RND_W'(prod);
    if (sh == '0) begin
      res = ext;
    end else begin
      half = RND_W'(1) << (sh - SHIFT_W'(1));
      res  = (ext + half) >>> sh;
    end
    return res;
  endfunction

  // Negative values scaled by 13/128 with rounding; others pass through.
  function automatic logic signed [LKY_W-1:0] leaky_relu(
    input logic signed [RND_W-1:0] r,
    input logic                    en
  );
    logic signed [LKY_W-1:0] w;
    w = LKY_W'(r);
    if (en && (r < 0)) begin
      w = (w * LKY_W'(LEAKY_MUL) + LKY_W'(1 <<< (LEAKY_SHIFT - 1))) >>> LEAKY_SHIFT;
    end
    return w;
  endfunction

  logic        adv;
  logic        take;

  s1_payload_t pay_p1_d, pay_p1_q;
  s2_payload_t pay_p2_d, pay_p2_q;
  logic        vld_p1_d, vld_p1_q;
  logic        vld_p2_d, vld_p2_q;
  logic        vld_p3_d, vld_p3_q;
  logic signed [7:0] out_data_d, out_data_q;
  logic        sat_d, sat_q;

  logic signed [RND_W-1:0] rnd_p2;
  logic signed [LKY_W-1:0] lky_p2;
  logic signed [7:0]       clamp_p2;
  logic                    clamp_sat_p2;

  assign rnd_p2 = round_shift(pay_p2_q.value, pay_p2_q.shift);
  assign lky_p2 = leaky_relu(rnd_p2, pay_p2_q.leaky_en);

  sat_clamp_int8 #(
    .IN_W (LKY_W)
  ) u_clamp (
    .din  (lky_p2),
    .dout (clamp_p2),
    .sat  (clamp_sat_p2)
  );

  always_comb begin
    // Whole pipeline moves as one; bubbles are not collapsed.
    adv      = !vld_p3_q || out_ready;
    in_ready = rst_n && adv;
    take     = in_valid && in_ready;

    pay_p1_d   = pay_p1_q;
    pay_p2_d   = pay_p2_q;
    vld_p1_d   = vld_p1_q;
    vld_p2_d   = vld_p2_q;
    vld_p3_d   = vld_p3_q;
    out_data_d = out_data_q;
    sat_d      = sat_q;

    if (adv) begin
      // ---- stage 1: bias add ----
      vld_p1_d          = take;
      pay_p1_d.value    = SUM_W'(acc_in) + SUM_W'(bias);
      pay_p1_d.scale    = scale;
      pay_p1_d.shift    = shift;
      pay_p1_d.leaky_en = leaky_en;

      // ---- stage 2: scale multiply ----
      vld_p2_d          = vld_p1_q;
      pay_p2_d.value    = PROD_W'($signed(pay_p1_q.value)) *
                          PROD_W'($signed({1'b0, pay_p1_q.scale}));
      pay_p2_d.shift    = pay_p1_q.shift;
      pay_p2_d.leaky_en = pay_p1_q.leaky_en;

      // ---- stage 3: round, leaky, clamp ----
      vld_p3_d = vld_p2_q;
      // Result registers only load real elements, so they stay at their
      // last (or reset) value across bubbles.
      if (vld_p2_q) begin
        out_data_d = clamp_p2;
        sat_d      = clamp_sat_p2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      vld_p3_q   <= 1'b0;
      out_data_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      vld_p3_q   <= vld_p3_d;
      out_data_q <= out_data_d;
      sat_q      <= sat_d;
    end
  end

  always_ff @(posedge clk) begin
    pay_p1_q <= pay_p1_d;
    pay_p2_q <= pay_p2_d;
  end

  assign out_valid = vld_p3_q;
  assign out_data  = out_data_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_requant_int8.sv
// tb_requant_int8
// Scoreboard bench for requant_int8: expectations are queued when an
// element is accepted and compared when the DUT hands it downstream.
module tb_requant_int8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] acc_in;
  logic signed [31:0] bias;
  logic        [15:0] scale;
  logic        [4:0]  shift;
  logic               leaky_en;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic               sat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [7:0] d;
    logic              s;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  requant_int8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_in    (acc_in),
    .bias      (bias),
    .scale     (scale),
    .shift     (shift),
    .leaky_en  (leaky_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat       (sat)
  );

  // Reference arithmetic at 64 bits.
  function automatic exp_t model(input int acc, input int b, input int unsigned sc,
                                 input int sh, input bit lk);
    exp_t   e;
    longint s, p, r;
    s = longint'(acc) + longint'(b);
    p = s * longint'(sc);
    if (sh == 0) r = p;
    else         r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
    if (lk && r < 0) r = (r * 13 + 64) >>> 7;
    if (r > 127) begin
      e.d = 8'sh7F; e.s = 1'b1;
    end else if (r < -128) begin
      e.d = 8'sh80; e.s = 1'b1;
    end else begin
      e.d = 8'(r); e.s = 1'b0;
    end
    return e;
  endfunction

  // Output side of the scoreboard: a transfer completes at the next edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got data=%0d sat=%0b required=no output",
                 out_data, sat);
      end else begin
        e = sbq.pop_front();
        if (out_data !== e.d || sat !== e.s) begin
          errors++;
          $display("FAIL output_data got data=%0d sat=%0b required data=%0d sat=%0b",
                   out_data, sat, e.d, e.s);
        end
      end
    end
  end

  // Present one element, hold until accepted, queue its expected result.
  task automatic send(input int acc, input int b, input int unsigned sc, input int sh,
                      input bit lk, input int ed, input bit es);
    exp_t e;
    bit   ok;
    ok       = 1'b0;
    acc_in   = acc;
    bias     = b;
    scale    = sc[15:0];
    shift    = sh[4:0];
    leaky_en = lk;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout got in_ready=0 for 20 cycles required acceptance");
    end else begin
      e.d = ed[7:0];
      e.s = es;
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sbq.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d outstanding required 0", sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %0b required 0", out_valid);
    end
    checks++;
    if (out_data !== 8'sd0 || sat !== 1'b0) begin
      errors++; $display("FAIL reset_data got data=%0d sat=%0b required 0 0", out_data, sat);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %0b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic v1, v2, v3;
    send(100, -4, 3, 2, 1'b0, 72, 1'b0);
    @(negedge clk); v1 = out_valid;
    @(negedge clk); v2 = out_valid;
    @(negedge clk); v3 = out_valid;
    checks++;
    if (v1 !== 1'b0 || v2 !== 1'b0 || v3 !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency got valid seq=%0b%0b%0b required 001", v1, v2, v3);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_rounding();
    send(5,  0, 1, 1, 1'b0, 3,  1'b0);
    send(-5, 0, 1, 1, 1'b0, -2, 1'b0);
    send(6,  0, 1, 0, 1'b0, 6,  1'b0);
    drain();
  endtask

  task automatic test_saturation();
    send(1000, 24, 1, 0, 1'b0, 127, 1'b1);
    send(32'h7FFFFFFF, 32'h7FFFFFFF, 65535, 0, 1'b0, 127, 1'b1);
    send(-1000, 0, 1, 0, 1'b0, -128, 1'b1);
    send(127, 0, 1, 0, 1'b0, 127, 1'b0);
    send(-128, 0, 1, 0, 1'b0, -128, 1'b0);
    drain();
  endtask

  task automatic test_leaky();
    send(-100, 0, 1, 0, 1'b1, -10,  1'b0);
    send(-100, 0, 1, 0, 1'b0, -100, 1'b0);
    send(50,   0, 1, 0, 1'b1, 50,   1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    int          a[8];
    int          b[8];
    int unsigned sc[8];
    int          sh[8];
    bit          lk[8];
    exp_t        ex[8];
    for (int i = 0; i < 8; i++) begin
      a[i]  = int'($urandom_range(0, 4000)) - 2000;
      b[i]  = int'($urandom_range(0, 200)) - 100;
      sc[i] = $urandom_range(1, 300);
      sh[i] = int'($urandom_range(0, 12));
      lk[i] = 1'($urandom_range(0, 1));
      ex[i] = model(a[i], b[i], sc[i], sh[i], lk[i]);
    end
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(a[i], b[i], sc[i], sh[i], lk[i], int'(ex[i].d), ex[i].s);
      end
      begin
        logic signed [7:0] held_d;
        logic              held_s;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        held_d = out_data;
        held_s = sat;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_entry got in_ready=%0b out_valid=%0b required 0 1", in_ready, out_valid);
        end
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0 || out_data !== held_d || sat !== held_s) begin
            errors++;
            $display("FAIL stall_hold got in_ready=%0b data=%0d sat=%0b required 0 %0d %0b",
                     in_ready, out_data, sat, held_d, held_s);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_reset_midstream();
    logic v1, v2, v3;
    bit   quiet;
    send(10, 0, 1, 0, 1'b0, 10, 1'b0);
    send(20, 0, 1, 0, 1'b0, 20, 1'b0);
    send(30, 0, 1, 0, 1'b0, 30, 1'b0);
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_in_ready got %0b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_out_valid got %0b required 0", out_valid);
    end
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL midreset_flush got out_valid=1 required 0 after reset");
    end
    @(posedge clk);
    #1;
    send(-7, 1, 2, 1, 1'b0, -6, 1'b0);
    @(negedge clk); v1 = out_valid;
    @(negedge clk); v2 = out_valid;
    @(negedge clk); v3 = out_valid;
    checks++;
    if (v1 !== 1'b0 || v2 !== 1'b0 || v3 !== 1'b1) begin
      errors++;
      $display("FAIL midreset_latency got valid seq=%0b%0b%0b required 001", v1, v2, v3);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    in_valid  = 1'b0;
    acc_in    = '0;
    bias      = '0;
    scale     = '0;
    shift     = '0;
    leaky_en  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_leaky();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
